// File: rtl/mem_pkg.sv
// mem_pkg: funct3 codes, FSM states and access-size helpers shared by the load/store unit
// No ports; imported by mem_lane_align and mem_access_unit.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_BU) ? 3'd1 : (f3 == F3_H || f3 == F3_HU) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement for stores and extraction/extension for loads
// Ports: off/funct3 describe the access; wdata is LSB-aligned store data;
//        rdata_lo/rdata_hi are beat 0/1 read words; wstrb/wdata_lanes span two
//        words (low half = beat 0); rdata_ext is the extended load result.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_lanes,
    output logic [31:0] rdata_ext
);
    logic [2:0]  size;
    logic [7:0]  size_mask;
    logic [31:0] rshift;

    always_comb begin
        size        = access_size(funct3);
        size_mask   = size == 3'd4 ? 8'h0F : size == 3'd2 ? 8'h03 : 8'h01;
        wstrb       = size_mask << off;
        wdata_lanes = {32'b0, wdata} << {off, 3'b000};
        rshift      = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
        rdata_ext   = funct3 == F3_B  ? {{24{rshift[7]}}, rshift[7:0]} :
                      funct3 == F3_H  ? {{16{rshift[15]}}, rshift[15:0]} :
                      funct3 == F3_BU ? {24'b0, rshift[7:0]} :
                      funct3 == F3_HU ? {16'b0, rshift[15:0]} : rshift;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine splitting pipeline accesses into word beats
// Ports: req_* pipeline request (valid/ready), resp_* one-cycle response with
//        registered data/flags, mem_* word-wide beat interface (valid/ready
//        request, rvalid completion for reads and writes).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              beat;
    logic [1:0]        nbeats;
    logic [31:0]       slot0, slot1;
    logic [7:0]        wstrb8;
    logic [63:0]       wdata64;
    logic [31:0]       ext, lo, hi;
    logic [2:0]        req_end;
    logic              legal, split, last;

    assign legal   = funct3_legal(req_we, req_funct3);
    assign req_end = {1'b0, req_addr[1:0]} + access_size(req_funct3);
    assign split   = req_end > 3'd4;
    assign last    = beat || nbeats == 2'd1;

    // The word arriving this cycle stands in for its slot so the final
    // response can be registered on the same edge that captures it.
    assign lo = beat ? slot0 : mem_rdata;
    assign hi = beat ? mem_rdata : slot1;

    mem_lane_align u_align (
        .off        (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .rdata_lo   (lo),
        .rdata_hi   (hi),
        .wstrb      (wstrb8),
        .wdata_lanes(wdata64),
        .rdata_ext  (ext)
    );

    assign req_ready     = state == IDLE && !rst;
    assign resp_valid    = state == RESP;
    assign mem_req_valid = state == ISSUE;
    assign mem_we        = we_q;
    assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, beat, 2'b00};
    assign mem_wdata     = beat ? wdata64[63:32] : wdata64[31:0];
    assign mem_wstrb     = !we_q ? 4'b0000 : beat ? wstrb8[7:4] : wstrb8[3:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = (!legal || (split && !ALLOW_MISALIGNED)) ? RESP : ISSUE;
            ISSUE:   if (mem_req_ready) state_nx = WAIT;
            WAIT:    if (mem_rvalid) state_nx = last ? RESP : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            f3_q          <= 3'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat          <= 1'b0;
            nbeats        <= 2'd0;
            slot0         <= '0;
            slot1         <= '0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                beat    <= 1'b0;
                nbeats  <= split ? 2'd2 : 2'd1;
                if (state_nx == RESP) begin
                    resp_rdata    <= '0;
                    resp_err      <= !legal;
                    resp_misalign <= legal;
                end
            end
            if (state == WAIT && mem_rvalid) begin
                if (beat) slot1 <= mem_rdata;
                else slot0 <= mem_rdata;
                if (!last) beat <= 1'b1;
                if (last) begin
                    resp_rdata    <= we_q ? 32'b0 : ext;
                    resp_err      <= 1'b0;
                    resp_misalign <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against hand-computed values
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_valid1 = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        req_ready, resp_valid, resp_err, resp_misalign;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ready = 1'b1, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'b0;

    logic        rr1, rv1, re1, rm1, mv1, mwe1;
    logic [31:0] rd1, ma1, mwd1;
    logic [3:0]  mws1;
    logic        m1_ready = 1'b1, m1_rvalid = 1'b0;
    logic [31:0] m1_rdata = 32'b0;

    mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_misalign(resp_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(rr1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .resp_misalign(rm1),
        .mem_req_valid(mv1), .mem_req_ready(m1_ready), .mem_we(mwe1),
        .mem_addr(ma1), .mem_wdata(mwd1), .mem_wstrb(mws1),
        .mem_rvalid(m1_rvalid), .mem_rdata(m1_rdata)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h80FF_1234;
            32'h0000_1000: return 32'h4433_2211;
            32'h0000_1004: return 32'h8877_6655;
            32'h0000_0300: return 32'h1234_5678;
            32'h0000_0000: return 32'h8001_0000;
            default:       return 32'h0;
        endcase
    endfunction

    int          hs_cnt = 0, done_cnt = 0, m1_cnt = 0;
    logic [31:0] pend_addr = 32'b0;
    logic        hold_rv = 1'b0, force_rv = 1'b0;
    logic [31:0] log_addr[$], log_wdata[$];
    logic [3:0]  log_strb[$];
    logic        log_we[$];

    always @(posedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            hs_cnt++;
            pend_addr = mem_addr;
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            log_strb.push_back(mem_wstrb);
            log_we.push_back(mem_we);
        end
    end

    always @(negedge clk) begin
        if (rst) done_cnt = hs_cnt;
        mem_rvalid = force_rv;
        mem_rdata  = force_rv ? 32'hBAD0_BAD0 : 32'h0;
        if (hs_cnt != done_cnt && !hold_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd(pend_addr);
            done_cnt   = hs_cnt;
        end
        if (mv1) m1_cnt++;
    end

    int vecs = 0, errs = 0, lat = 0, base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        step;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        base = log_addr.size();
        step;
        req_valid = 1'b0;
        lat = 1;
    endtask

    task automatic wait_resp(input string tag);
        while (!resp_valid && lat < 40) begin
            step;
            lat++;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        step;
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        send(1'b0, F3_B, 32'h0000_0103, 32'h0);
        wait_resp("lb");
        check("lb_latency", 32'(lat), 32'd3);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_err", 32'(resp_err), 32'd0);
        check("lb_beats", 32'(log_addr.size() - base), 32'd1);
        check("lb_addr", log_addr[base], 32'h0000_0100);
        check("lb_strb", 32'(log_strb[base]), 32'h0);

        send(1'b1, F3_H, 32'h0000_0202, 32'hDEAD_BEEF);
        wait_resp("sh");
        check("sh_latency", 32'(lat), 32'd3);
        check("sh_rdata", resp_rdata, 32'h0);
        check("sh_beats", 32'(log_addr.size() - base), 32'd1);
        check("sh_addr", log_addr[base], 32'h0000_0200);
        check("sh_strb", 32'(log_strb[base]), 32'hC);
        check("sh_wdata_hi", 32'(log_wdata[base][31:16]), 32'hBEEF);
        check("sh_we", 32'(log_we[base]), 32'd1);

        send(1'b0, F3_W, 32'h0000_1001, 32'h0);
        wait_resp("lw_split");
        check("lw_split_latency", 32'(lat), 32'd5);
        check("lw_split_rdata", resp_rdata, 32'h5544_3322);
        check("lw_split_beats", 32'(log_addr.size() - base), 32'd2);
        check("lw_split_addr0", log_addr[base], 32'h0000_1000);
        check("lw_split_addr1", log_addr[base+1], 32'h0000_1004);

        send(1'b1, F3_BU, 32'h0000_0040, 32'h1111_2222);
        wait_resp("st_illegal");
        check("st_illegal_latency", 32'(lat), 32'd1);
        check("st_illegal_err", 32'(resp_err), 32'd1);
        check("st_illegal_misalign", 32'(resp_misalign), 32'd0);
        check("st_illegal_rdata", resp_rdata, 32'h0);
        check("st_illegal_beats", 32'(log_addr.size() - base), 32'd0);

        step;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_1001; req_valid1 = 1'b1;
        step;
        req_valid1 = 1'b0;
        check("strict_resp_valid", 32'(rv1), 32'd1);
        check("strict_misalign", 32'(rm1), 32'd1);
        check("strict_err", 32'(re1), 32'd0);
        check("strict_rdata", rd1, 32'h0);
        check("strict_mem_traffic", 32'(m1_cnt), 32'd0);

        send(1'b1, F3_W, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        wait_resp("sw_wrap");
        check("sw_wrap_latency", 32'(lat), 32'd5);
        check("sw_wrap_beats", 32'(log_addr.size() - base), 32'd2);
        check("sw_wrap_addr0", log_addr[base], 32'hFFFF_FFFC);
        check("sw_wrap_strb0", 32'(log_strb[base]), 32'hC);
        check("sw_wrap_wdata0", log_wdata[base], 32'hF00D_0000);
        check("sw_wrap_addr1", log_addr[base+1], 32'h0000_0000);
        check("sw_wrap_strb1", 32'(log_strb[base+1]), 32'h3);
        check("sw_wrap_wdata1", log_wdata[base+1], 32'h0000_CAFE);

        mem_req_ready = 1'b0;
        send(1'b0, F3_W, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_addr", mem_addr, 32'h0000_0300);
            if (i < 4) step;
        end
        mem_req_ready = 1'b1;
        wait_resp("stall");
        check("stall_rdata", resp_rdata, 32'h1234_5678);
        check("stall_beats", 32'(log_addr.size() - base), 32'd1);

        hold_rv = 1'b1;
        send(1'b0, F3_W, 32'h0000_0400, 32'h0);
        step;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_resp_rdata", resp_rdata, 32'h0);
        step;
        rst = 1'b0;
        hold_rv = 1'b0;
        force_rv = 1'b1;
        step;
        force_rv = 1'b0;
        check("stray_resp_valid", 32'(resp_valid), 32'd0);
        step;
        check("stray_req_ready", 32'(req_ready), 32'd1);
        check("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);

        send(1'b0, F3_HU, 32'h0000_0002, 32'h0);
        wait_resp("lhu");
        check("lhu_latency", 32'(lat), 32'd3);
        check("lhu_rdata", resp_rdata, 32'h0000_8001);
        check("lhu_addr", log_addr[base], 32'h0000_0000);

        step;
        check("final_idle_resp_valid", 32'(resp_valid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised load/store engine between the pipeline MEM stage and a word-wide backing memory with valid/ready handshakes and variable latency.
- Translates {we, funct3, addr, wdata} into aligned word beats with byte strobes.
- Splits misaligned accesses into two beats.
- Extracts and sign/zero-extends load data.
- Returns a single-cycle response with error flags.
- One request outstanding at a time.

Parameters:
ADDR_W, 32, byte address width.
ALLOW_MISALIGNED, 1, 1 = split accesses that cross a word boundary; 0 = flag them as errors with no memory traffic.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept a request (high only in IDLE while rst=0)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  funct3 of the load/store instruction
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3
resp_misalign  out  1  misaligned access with ALLOW_MISALIGNED=0
mem_req_valid  out  1  beat request to memory
mem_req_ready  in  1  memory accepts the beat
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  word-aligned beat address (low 2 bits = 0)
mem_wdata  out  32  beat write data
mem_wstrb  out  4  byte enables (0000 for reads)
mem_rvalid  in  1  read data / write acknowledge for the current beat
mem_rdata  in  32  beat read data

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Beat counter `beat` (0/1) and `nbeats` (1/2).
- Reset (async, rst=1): state=IDLE; all outputs 0, including req_ready; latched request, beat data and counters cleared. Reset mid-transaction abandons it: no response, memory handshake dropped immediately.
- IDLE: req_ready=1. On req_valid, latch the request, then:
  - Illegal funct3 (load: only 000/001/010/100/101 legal; store: only 000/001/010 legal) → RESP with resp_err=1.
  - Else misaligned and ALLOW_MISALIGNED=0 → RESP with resp_misalign=1.
  - Else → ISSUE with beat=0.
- Size from funct3[1:0]: 1, 2 or 4 bytes. off = addr[1:0]. Misaligned iff off+size > 4; then nbeats=2.
- ISSUE: mem_req_valid=1 and all mem_* fields stable until mem_req_ready. Then → WAIT.
  - mem_addr = {addr[ADDR_W-1:2],00} + 4*beat, wrapping modulo 2^ADDR_W.
- Strobes and write data: 8-bit mask = ((1<<size)-1) << off; 64-bit data = zext(wdata) << (8*off). Beat 0 uses the low halves, beat 1 the high halves. Store bytes outside size are ignored.
- WAIT: on mem_rvalid, capture mem_rdata into slot[beat].
  - If beat+1 < nbeats: beat++, → ISSUE.
  - Else → RESP.
  - mem_rvalid outside WAIT is ignored.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. No response backpressure.
  - Loads: val = {slot1,slot0} >> (8*off); take low size bytes; sign-extend for 000/001, zero-extend for 100/101.
- Latency from accept, with zero memory wait: aligned = 3 cycles to resp_valid; split = 5 cycles.
- Response outputs are registered: resp_rdata/err/misalign hold their values until the next response. resp_valid is 0 outside RESP.

Decomposition:
- mem_pkg:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
  - state enum;
  - funct3_legal(we, f3) function;
  - access_size(f3) function.
- Sub-module mem_lane_align (combinational): wstrb/wdata lane generation for stores; shift and extension for loads. Shared by both paths and unit-tested standalone.

Test Plan:
- LB at addr 0x103, mem word 0x80FF_1234 → one beat to 0x100; resp_rdata=0xFFFF_FF80; resp_valid 3 cycles after accept.
- SH at 0x202, wdata 0xDEAD_BEEF → one write beat: mem_addr=0x200, wstrb=1100, mem_wdata[31:16]=0xBEEF.
- LW at 0x1001, ALLOW_MISALIGNED=1, words 0x4433_2211 @0x1000 and 0x8877_6655 @0x1004 → two beats; resp_rdata=0x5544_3322.
  - Same request with ALLOW_MISALIGNED=0 → no mem_req_valid, resp_misalign=1.
- SW at 0xFFFF_FFFE → beat addresses 0xFFFF_FFFC (wstrb 1100) then 0x0000_0000 (wstrb 0011).
- Store with funct3=100 → no memory traffic, resp_err=1, resp_rdata=0; mem_req_ready held low 5 cycles during a load → mem_req_valid and mem_addr stable throughout.
- rst pulsed during WAIT → outputs 0 immediately; stray mem_rvalid afterwards ignored; the next LHU at 0x2 of word 0x8001_0000 returns 0x0000_8001.
